src_stream_tx: RTL

SRC_STREAM_TX -- requirements
Module: src_stream_tx

---
 rtl/dnn_stream_pkg.sv | 15 +
 rtl/stream_fifo.sv | 64 ++++++
 rtl/src_stream_tx.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dnn_stream_pkg.sv
// Shared definitions for the DNN stream blocks: default widths and the
// transmit FSM state encoding.
package dnn_stream_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_LW    = 12;
  localparam int DEF_DEPTH = 16;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t ST_IDLE = 2'd0;
  localparam tx_state_t ST_SEND = 2'd1;
  localparam tx_state_t ST_FIN  = 2'd2;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO with registered pointers and occupancy count.
// With SRC_TX_ABORT_EN defined it gains a flush input that empties it in one cycle.
module stream_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef SRC_TX_ABORT_EN
  input  logic          flush,
`endif
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [DW-1:0] mem [DEPTH];
  logic          wr_ok;
  logic          rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end
`ifdef SRC_TX_ABORT_EN
    else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end
`endif
    else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/src_stream_tx.sv
// Host-to-accelerator frame transmitter: FIFO, frame FSM and a registered output beat.
// Optional SRC_TX_ABORT_EN adds an abort input that flushes everything back to idle.
module src_stream_tx
  import dnn_stream_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LW    = DEF_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          start,
  input  logic [LW-1:0] frame_len,
  output logic          busy,
  output logic          done,
  output logic          src_valid,
  output logic [DW-1:0] src_data,
  output logic          src_last,
`ifdef SRC_TX_ABORT_EN
  input  logic          abort,
`endif
  input  logic          src_ready
);

  tx_state_t     state;
  tx_state_t     state_nxt;
  logic [LW-1:0] beats_left;
  logic          accept_en;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fire;
  logic          load;

  assign wr_ready = accept_en && !fifo_full;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_FIN);
  assign fire     = src_valid && src_ready;
  // Refill the output register when it is empty or being drained this cycle.
  assign load     = (state == ST_SEND) && (beats_left != '0) && !fifo_empty
                    && (!src_valid || src_ready);

  stream_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef SRC_TX_ABORT_EN
    .flush   (abort),
`endif
    .wr_en   (wr_valid && wr_ready),
    .wr_data (wr_data),
    .rd_en   (load),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Keeps wr_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) accept_en <= 1'b0;
    else        accept_en <= 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (frame_len == '0) ? ST_FIN : ST_SEND;
      ST_SEND: if (fire && src_last) state_nxt = ST_FIN;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      beats_left <= '0;
    end
`ifdef SRC_TX_ABORT_EN
    else if (abort) begin
      state      <= ST_IDLE;
      beats_left <= '0;
    end
`endif
    else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) beats_left <= frame_len;
      else if (load)                 beats_left <= beats_left - 1'b1;
    end
  end

  // The beat counts words not yet issued, so the final issued word carries src_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_valid <= 1'b0;
      src_data  <= '0;
      src_last  <= 1'b0;
    end
`ifdef SRC_TX_ABORT_EN
    else if (abort) begin
      src_valid <= 1'b0;
      src_data  <= '0;
      src_last  <= 1'b0;
    end
`endif
    else if (load) begin
      src_valid <= 1'b1;
      src_data  <= fifo_rdata;
      src_last  <= (beats_left == LW'(1));
    end else if (fire) begin
      src_valid <= 1'b0;
      src_last  <= 1'b0;
    end
  end

endmodule
